// File: rtl/display_bcd_mux.sv
// rtl/display_bcd_mux.sv - latch a binary result, convert it to BCD by shift-and-add-3,
// and scan it onto an N-digit active-low 7-segment display with leading-zero blanking.
module display_bcd_mux #(
  parameter int ANCHO_DATO      = 10,
  parameter int N_DIGITOS       = 4,
  parameter int CICLOS_REFRESCO = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ANCHO_DATO-1:0] valor,
  input  logic                  cargar,
  input  logic                  borrar,
  output logic                  ocupado,
  output logic [6:0]            seg,
  output logic [N_DIGITOS-1:0]  an
);

  localparam int BCD_W = 4 * N_DIGITOS;
  localparam int CNT_W = $clog2(ANCHO_DATO + 1);
  localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int REF_W = $clog2(CICLOS_REFRESCO);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]          MAX_VAL  = pow10(N_DIGITOS) - 64'd1;
  localparam logic [N_DIGITOS-1:0] AN_RESET = ~(N_DIGITOS'(1));
  localparam logic [6:0]           SEG_OFF  = 7'b1111111;
  localparam logic [6:0]           SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {REPOSO, CONVIERTE, ACTUALIZA} estado_t;

  estado_t                estado_q, estado_d;
  logic [ANCHO_DATO-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [BCD_W-1:0]       disp_q, disp_d;
  logic                   disp_ovf_q, disp_ovf_d;
  logic                   disp_blank_q, disp_blank_d;
  logic [REF_W-1:0]       ref_q, ref_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_DIGITOS-1:0]   an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic [63:0]            valor_ext;
  logic [N_DIGITOS-1:0]   visible;
  logic [3:0]             digito;
  logic                   visto;

  assign valor_ext = 64'(valor);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    disp_d       = disp_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blank_d = disp_blank_q;
    case (estado_q)
      REPOSO: begin
        if (cargar) begin
          bin_d    = valor;
          bcd_d    = '0;
          cnt_d    = CNT_W'(ANCHO_DATO);
          ovf_d    = valor_ext > MAX_VAL;
          estado_d = CONVIERTE;
        end
      end
      CONVIERTE: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) estado_d = ACTUALIZA;
      end
      ACTUALIZA: begin
        disp_d       = bcd_q;
        disp_ovf_d   = ovf_q;
        disp_blank_d = 1'b0;
        estado_d     = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
    // borrar wins over everything, including a cargar in the same cycle
    if (borrar) begin
      estado_d     = REPOSO;
      disp_blank_d = 1'b1;
      disp_ovf_d   = 1'b0;
    end
  end

  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_W'(CICLOS_REFRESCO - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITOS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is visible if it or any more significant digit is non-zero; digit 0 always is.
  always_comb begin
    visto   = 1'b0;
    visible = '0;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      visto      = visto | (disp_q[4*i +: 4] != 4'd0) | (i == 0);
      visible[i] = visto;
    end
  end

  always_comb begin
    digito = disp_q[{idx_q, 2'b00} +: 4];
    an_d   = ~(N_DIGITOS'(1) << idx_q);
    seg_d  = SEG_OFF;
    if (disp_blank_q) begin
      seg_d = SEG_OFF;
    end else if (disp_ovf_q) begin
      seg_d = SEG_DASH;
    end else if (visible[idx_q]) begin
      case (digito)
        4'd0:    seg_d = 7'b1000000;
        4'd1:    seg_d = 7'b1111001;
        4'd2:    seg_d = 7'b0100100;
        4'd3:    seg_d = 7'b0110000;
        4'd4:    seg_d = 7'b0011001;
        4'd5:    seg_d = 7'b0010010;
        4'd6:    seg_d = 7'b0000010;
        4'd7:    seg_d = 7'b1111000;
        4'd8:    seg_d = 7'b0000000;
        4'd9:    seg_d = 7'b0010000;
        default: seg_d = SEG_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q     <= REPOSO;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      disp_q       <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blank_q <= 1'b1;
      ref_q        <= '0;
      idx_q        <= '0;
      an_q         <= AN_RESET;
      seg_q        <= SEG_OFF;
    end else begin
      estado_q     <= estado_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      disp_q       <= disp_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blank_q <= disp_blank_d;
      ref_q        <= ref_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign ocupado = (estado_q != REPOSO);
  assign seg     = seg_q;
  assign an      = an_q;

endmodule
